// File: rtl/sdp_delay_ram.sv
// Simple dual-port delay memory with a registered read port.
// A read and a write to the same address in one cycle return the old word.
module sdp_delay_ram #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM; stale contents are never used
    // because the caller gates the read data until the window has filled.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/boxcar_fir.sv
// Runtime-length moving-sum filter: accumulator adds the newest sample and
// subtracts the one leaving the window, with a fixed two-clock latency.
module boxcar_fir #(
    parameter int IW    = 16,
    parameter int LGMEM = 6
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [LGMEM-1:0]        i_navg,
    input  logic                    i_ce,
    input  logic [IW-1:0]           i_sample,
    output logic                    o_ce,
    output logic [IW+LGMEM-1:0]     o_result
);

    localparam int OW = IW + LGMEM;
    localparam logic [LGMEM:0]   ONE_N = 1;
    localparam logic [LGMEM-1:0] ONE_A = 1;

    logic [LGMEM:0]   n_q, fill_q;
    logic [LGMEM-1:0] wraddr_q, rdaddr;
    logic [IW-1:0]    sample_q, rdata;
    logic             primed_q, v0_q, v1_q, ce_q;
    logic [IW:0]      diff_q, diff_d;
    logic [OW-1:0]    acc_q, acc_d, result_q;
    logic             accept;

    assign accept = i_ce && !i_reset;

    // With N = 2^LGMEM the truncated offset is zero, so the read hits the slot
    // being overwritten and relies on read-before-write to fetch the oldest sample.
    assign rdaddr = wraddr_q - n_q[LGMEM-1:0];

    sdp_delay_ram #(
        .DW(IW),
        .AW(LGMEM)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (accept),
        .i_waddr(wraddr_q),
        .i_wdata(i_sample),
        .i_re   (accept),
        .i_raddr(rdaddr),
        .o_rdata(rdata)
    );

    assign diff_d = {sample_q[IW-1], sample_q} - (primed_q ? {rdata[IW-1], rdata} : '0);
    assign acc_d  = acc_q + {{(OW-IW-1){diff_q[IW]}}, diff_q};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            n_q      <= {1'b0, i_navg} + ONE_N;
            fill_q   <= '0;
            wraddr_q <= '0;
            sample_q <= '0;
            primed_q <= 1'b0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            diff_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ce_q     <= 1'b0;
        end else begin
            v0_q <= i_ce;
            if (i_ce) begin
                sample_q <= i_sample;
                primed_q <= (fill_q == n_q);
                wraddr_q <= wraddr_q + ONE_A;
                if (fill_q != n_q) begin
                    fill_q <= fill_q + ONE_N;
                end
            end

            v1_q <= v0_q;
            if (v0_q) begin
                diff_q <= diff_d;
            end

            ce_q <= v1_q;
            if (v1_q) begin
                acc_q    <= acc_d;
                result_q <= acc_d;
            end
        end
    end

    assign o_ce     = ce_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_boxcar_fir.sv
// Directed self-checking bench for boxcar_fir: table of per-sample expected
// sums plus hand sequences for latency and mid-stream reset.
module tb_boxcar_fir;

    localparam int IW    = 16;
    localparam int LGMEM = 6;
    localparam int OW    = IW + LGMEM;

    logic                  i_clk = 1'b0;
    logic                  i_reset = 1'b0;
    logic [LGMEM-1:0]      i_navg = '0;
    logic                  i_ce = 1'b0;
    logic [IW-1:0]         i_sample = '0;
    logic                  o_ce;
    logic signed [OW-1:0]  o_result;

    boxcar_fir #(.IW(IW), .LGMEM(LGMEM)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_navg  (i_navg),
        .i_ce    (i_ce),
        .i_sample(i_sample),
        .o_ce    (o_ce),
        .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit               first;
        logic [LGMEM-1:0] navg;
        int               gap;
        int               sample;
        int               expv;
        string            name;
    } vec_t;

    vec_t vecs[$];
    int   got_q[$];
    int   exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge i_clk) begin
        if (o_ce === 1'b1) got_q.push_back(int'(o_result));
    end

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic add(input bit first, input int navg, input int gap,
                       input int sample, input int expv, input string name);
        vec_t v;
        v.first  = first;
        v.navg   = LGMEM'(navg);
        v.gap    = gap;
        v.sample = sample;
        v.expv   = expv;
        v.name   = name;
        vecs.push_back(v);
    endtask

    task automatic do_reset(input logic [LGMEM-1:0] navg);
        @(negedge i_clk);
        i_reset = 1'b1;
        i_navg  = navg;
        i_ce    = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0;
        // The length register must ignore i_navg once reset is released.
        i_navg  = navg ^ 6'h2A;
        repeat (3) @(negedge i_clk);
        got_q.delete();
    endtask

    task automatic flush_compare(input string name);
        @(negedge i_clk);
        i_ce = 1'b0;
        repeat (4) @(negedge i_clk);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check($sformatf("%s_out%0d", name, k), got_q[k], exp_q[k]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int    s6[7];
        int    e6[7];
        string cur;

        s6 = '{1, 2, 3, 4, 5, -6, 7};
        e6 = '{1, 3, 6, 10, 14, 6, 10};

        add(1, 0, 0, 5, 5, "n1");
        add(0, 0, 0, -7, -7, "n1");
        add(0, 0, 0, 32767, 32767, "n1");

        for (int k = 0; k < 4; k++) add(k == 0, 1, 0, k + 1, 2 * k + 1, "n2");

        for (int k = 0; k < 10; k++) add(k == 0, 7, 0, (k == 0) ? 100 : 0, (k < 8) ? 100 : 0, "n8imp");
        for (int k = 0; k < 10; k++) add(k == 0, 7, 0, 3, (k < 8) ? 3 * (k + 1) : 24, "n8dc");

        for (int k = 0; k < 64; k++) add(k == 0, 63, 0, -32768, -32768 * (k + 1), "n64");
        for (int k = 0; k < 64; k++) add(0, 63, 0, 32767, -2097152 + 65535 * (k + 1), "n64");

        for (int k = 0; k < 7; k++) add(k == 0, 3, 0, s6[k], e6[k], "n4dense");
        for (int k = 0; k < 7; k++) add(k == 0, 3, 2, s6[k], e6[k], "n4gap");

        do_reset(6'd0);
        check("reset_oce", int'(o_ce), 0);
        check("reset_result", int'(o_result), 0);

        cur = "";
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].first) begin
                if (i > 0) flush_compare(cur);
                do_reset(vecs[i].navg);
                cur = vecs[i].name;
            end
            @(negedge i_clk);
            i_ce     = 1'b1;
            i_sample = IW'(vecs[i].sample);
            exp_q.push_back(vecs[i].expv);
            for (int g = 0; g < vecs[i].gap; g++) begin
                @(negedge i_clk);
                i_ce = 1'b0;
            end
        end
        flush_compare(cur);

        // Latency: sample taken at edge E shows o_ce only after edge E+2.
        do_reset(6'd0);
        @(negedge i_clk);
        i_ce     = 1'b1;
        i_sample = 16'sd123;
        @(negedge i_clk);
        i_ce = 1'b0;
        check("lat_e0_oce", int'(o_ce), 0);
        @(negedge i_clk);
        check("lat_e1_oce", int'(o_ce), 0);
        @(negedge i_clk);
        check("lat_e2_oce", int'(o_ce), 1);
        check("lat_e2_result", int'(o_result), 123);
        @(negedge i_clk);
        check("lat_e3_oce", int'(o_ce), 0);
        check("lat_e3_held", int'(o_result), 123);
        got_q.delete();

        // Mid-stream reset: in-flight samples must never produce o_ce.
        do_reset(6'd3);
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            i_ce     = 1'b1;
            i_sample = 16'sd10;
        end
        @(negedge i_clk);
        i_reset  = 1'b1;
        i_navg   = 6'd1;
        i_sample = 16'sd99;
        @(posedge i_clk);
        #1;
        check("midrst_oce", int'(o_ce), 0);
        check("midrst_result", int'(o_result), 0);
        got_q.delete();
        @(negedge i_clk);
        i_reset  = 1'b0;
        i_navg   = 6'd9;
        i_ce     = 1'b1;
        i_sample = 16'sd1;
        @(negedge i_clk);
        i_sample = 16'sd1;
        exp_q.push_back(1);
        exp_q.push_back(2);
        flush_compare("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
